// File: rtl/cic_pkg.sv
// Shared types and helpers for the I/Q CIC decimator.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMB_I = 2'd1,
    COMB_Q = 2'd2,
    SCALE  = 2'd3
  } cic_state_t;

  // Register width needed for lossless growth: BITS + N*log2(Rmax).
  function automatic int cic_width(input int bits, input int stages, input int decim_bits);
    return bits + stages * decim_bits;
  endfunction

  // Largest positive value of an out_bits signed word; the minimum is its complement.
  function automatic longint sat_limit(input int out_bits);
    return (longint'(1) <<< (out_bits - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/cic_scale_sat.sv
// Arithmetic right shift of a wide comb result, then clamp into an OUT_BITS signed word.
module cic_scale_sat
  import cic_pkg::*;
#(
  parameter int WIDTH      = 68,
  parameter int SHIFT_BITS = 7,
  parameter int OUT_BITS   = 16
) (
  input  logic signed [WIDTH-1:0]    x,
  input  logic        [SHIFT_BITS-1:0] shift,
  output logic signed [OUT_BITS-1:0] y,
  output logic                       sat
);

  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(sat_limit(OUT_BITS));
  localparam logic signed [WIDTH-1:0] MIN_W = ~MAX_W;

  logic signed [WIDTH-1:0] xs;

  always_comb begin
    xs  = x >>> shift;
    sat = 1'b0;
    y   = xs[OUT_BITS-1:0];
    if (xs > MAX_W) begin
      y   = MAX_W[OUT_BITS-1:0];
      sat = 1'b1;
    end else if (xs < MIN_W) begin
      y   = MIN_W[OUT_BITS-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/cic_decim_iq.sv
// N-stage I/Q CIC decimator: per-channel integrators at tick rate, one comb
// subtractor time-shared between I and Q, runtime ratio and output shift.
module cic_decim_iq
  import cic_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int STAGES     = 5,
  parameter int DECIM_BITS = 12,
  parameter int WIDTH      = 68,
  parameter int SHIFT_BITS = 7,
  parameter int OUT_BITS   = 16
) (
  input  logic                         CLK,
  input  logic                         RSTb,
  input  logic                         in_tick,
  input  logic signed [BITS-1:0]       i_in,
  input  logic signed [BITS-1:0]       q_in,
  input  logic        [DECIM_BITS-1:0] decim,
  input  logic        [SHIFT_BITS-1:0] shift,
  output logic signed [OUT_BITS-1:0]   i_out,
  output logic signed [OUT_BITS-1:0]   q_out,
  output logic                         out_tick,
  output logic                         sat,
  output logic                         overrun
);

  localparam int MIN_WIDTH = cic_width(BITS, STAGES, DECIM_BITS);
  localparam int STG_W     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);

  generate
    if (WIDTH < MIN_WIDTH) begin : g_width_check
      $error("cic_decim_iq: WIDTH too small for BITS + STAGES*DECIM_BITS");
    end
  endgenerate

  logic signed [WIDTH-1:0] integ_i     [STAGES];
  logic signed [WIDTH-1:0] integ_q     [STAGES];
  logic signed [WIDTH-1:0] integ_i_nxt [STAGES];
  logic signed [WIDTH-1:0] integ_q_nxt [STAGES];

  logic [DECIM_BITS-1:0] cnt;
  logic [DECIM_BITS-1:0] r_lat;
  logic [DECIM_BITS-1:0] r_cmp;
  logic [DECIM_BITS-1:0] decim_eff;
  logic [SHIFT_BITS-1:0] shift_lat;
  logic                  init_q;
  logic                  period_end;

  cic_state_t              state;
  logic [STG_W-1:0]        stg;
  logic                    snap_pend;
  logic signed [WIDTH-1:0] snap_i;
  logic signed [WIDTH-1:0] snap_q;
  logic signed [WIDTH-1:0] dly_i [STAGES];
  logic signed [WIDTH-1:0] dly_q [STAGES];
  logic signed [WIDTH-1:0] comb_x;
  logic signed [WIDTH-1:0] comb_d;
  logic signed [WIDTH-1:0] comb_y;

  logic signed [OUT_BITS-1:0] i_sc;
  logic signed [OUT_BITS-1:0] q_sc;
  logic                       i_sat;
  logic                       q_sat;

  // Cascade within one tick so the snapshot sees the value including this tick.
  always_comb begin
    integ_i_nxt[0] = integ_i[0] + {{(WIDTH-BITS){i_in[BITS-1]}}, i_in};
    integ_q_nxt[0] = integ_q[0] + {{(WIDTH-BITS){q_in[BITS-1]}}, q_in};
    for (int k = 1; k < STAGES; k++) begin
      integ_i_nxt[k] = integ_i[k] + integ_i_nxt[k-1];
      integ_q_nxt[k] = integ_q[k] + integ_q_nxt[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else if (in_tick) begin
      integ_i <= integ_i_nxt;
      integ_q <= integ_q_nxt;
    end
  end

  // Ratios below 2 cannot form a period with a separate clear tick.
  assign decim_eff  = (decim < DECIM_BITS'(2)) ? DECIM_BITS'(2) : decim;
  assign r_cmp      = init_q ? decim_eff : r_lat;
  assign period_end = in_tick && (cnt == (r_cmp - DECIM_BITS'(1)));

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt       <= '0;
      r_lat     <= DECIM_BITS'(2);
      shift_lat <= '0;
      init_q    <= 1'b1;
    end else begin
      init_q <= 1'b0;
      if (init_q) begin
        r_lat     <= decim_eff;
        shift_lat <= shift;
      end
      if (in_tick) begin
        if (period_end) begin
          cnt       <= '0;
          r_lat     <= decim_eff;
          shift_lat <= shift;
        end else begin
          cnt <= cnt + DECIM_BITS'(1);
        end
      end
    end
  end

  // Single subtractor shared by both channels' comb chains.
  always_comb begin
    comb_x = (state == COMB_Q) ? snap_q : snap_i;
    comb_d = (state == COMB_Q) ? dly_q[stg] : dly_i[stg];
    comb_y = comb_x - comb_d;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state     <= IDLE;
      stg       <= '0;
      snap_pend <= 1'b0;
      snap_i    <= '0;
      snap_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
      i_out    <= '0;
      q_out    <= '0;
      out_tick <= 1'b0;
      sat      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      out_tick <= 1'b0;
      overrun  <= 1'b0;
      if (period_end) begin
        if (state == IDLE && !snap_pend) begin
          snap_i    <= integ_i_nxt[STAGES-1];
          snap_q    <= integ_q_nxt[STAGES-1];
          snap_pend <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (snap_pend) begin
            snap_pend <= 1'b0;
            stg       <= '0;
            state     <= COMB_I;
          end
        end
        COMB_I: begin
          snap_i     <= comb_y;
          dly_i[stg] <= snap_i;
          if (stg == STG_LAST) begin
            stg   <= '0;
            state <= COMB_Q;
          end else begin
            stg <= stg + STG_W'(1);
          end
        end
        COMB_Q: begin
          snap_q     <= comb_y;
          dly_q[stg] <= snap_q;
          if (stg == STG_LAST) begin
            stg   <= '0;
            state <= SCALE;
          end else begin
            stg <= stg + STG_W'(1);
          end
        end
        SCALE: begin
          i_out    <= i_sc;
          q_out    <= q_sc;
          sat      <= i_sat | q_sat;
          out_tick <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cic_scale_sat #(
    .WIDTH      (WIDTH),
    .SHIFT_BITS (SHIFT_BITS),
    .OUT_BITS   (OUT_BITS)
  ) u_scale_i (
    .x     (snap_i),
    .shift (shift_lat),
    .y     (i_sc),
    .sat   (i_sat)
  );

  cic_scale_sat #(
    .WIDTH      (WIDTH),
    .SHIFT_BITS (SHIFT_BITS),
    .OUT_BITS   (OUT_BITS)
  ) u_scale_q (
    .x     (snap_q),
    .shift (shift_lat),
    .y     (q_sc),
    .sat   (q_sat)
  );

endmodule

// File: tb/tb_cic_decim_iq.sv
// Directed bench for cic_decim_iq: reset, DC gain, saturation/wrap, ratio change,
// overrun and reset during the comb sequence.
module tb_cic_decim_iq;

  logic               CLK;
  logic               RSTb;
  logic               in_tick;
  logic signed [7:0]  i_in;
  logic signed [7:0]  q_in;
  logic [11:0]        decim;
  logic [6:0]         shift;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               out_tick;
  logic               sat;
  logic               overrun;

  cic_decim_iq #(
    .BITS(8), .STAGES(5), .DECIM_BITS(12), .WIDTH(68), .SHIFT_BITS(7), .OUT_BITS(16)
  ) dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .in_tick  (in_tick),
    .i_in     (i_in),
    .q_in     (q_in),
    .decim    (decim),
    .shift    (shift),
    .i_out    (i_out),
    .q_out    (q_out),
    .out_tick (out_tick),
    .sat      (sat),
    .overrun  (overrun)
  );

  localparam int LAT = 12;  // 2*STAGES+2

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int                 tk_cyc[$];
  int                 ot_cyc[$];
  logic signed [15:0] ot_i[$];
  logic signed [15:0] ot_q[$];
  logic               ot_sat[$];
  int                 ovr_cnt = 0;
  int                 n_wide  = 0;
  logic               prev_ot = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (out_tick === 1'b1) begin
      ot_cyc.push_back(cyc);
      ot_i.push_back(i_out);
      ot_q.push_back(q_out);
      ot_sat.push_back(sat);
      if (prev_ot) n_wide++;
    end
    prev_ot = (out_tick === 1'b1);
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int gap, input logic signed [7:0] iv, input logic signed [7:0] qv);
    i_in = iv;
    q_in = qv;
    in_tick = 1'b1;
    tk_cyc.push_back(cyc + 1);
    step();
    in_tick = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic do_reset(input string tag);
    RSTb = 1'b0;
    #1;
    check_val({tag, "_i_out"}, i_out, 0);
    check_val({tag, "_q_out"}, q_out, 0);
    check_val({tag, "_out_tick"}, out_tick, 0);
    check_val({tag, "_sat"}, sat, 0);
    check_val({tag, "_overrun"}, overrun, 0);
    repeat (2) step();
    tk_cyc.delete();
    ot_cyc.delete();
    ot_i.delete();
    ot_q.delete();
    ot_sat.delete();
    ovr_cnt = 0;
    RSTb = 1'b1;
  endtask

  initial begin
    int min_gap;
    RSTb    = 1'b1;
    in_tick = 1'b0;
    i_in    = '0;
    q_in    = '0;
    decim   = 12'd4;
    shift   = 7'd0;
    step();

    // DC gain: R=4, N=5 -> 4^5 = 1024
    do_reset("rst0");
    for (int k = 0; k < 32; k++) send(4, 8'sd1, -8'sd1);
    repeat (20) step();
    check_val("dc_count", ot_cyc.size(), 8);
    for (int k = 5; k < 8; k++) begin
      check_val($sformatf("dc_i_%0d", k), ot_i[k], 1024);
      check_val($sformatf("dc_q_%0d", k), ot_q[k], -1024);
      check_val($sformatf("dc_sat_%0d", k), ot_sat[k], 0);
    end

    // Mid-stream reset, then timing with R=8 and a tick every 4 cycles
    for (int k = 0; k < 3; k++) send(4, 8'sd1, -8'sd1);
    decim = 12'd8;
    do_reset("rst_mid");
    for (int k = 0; k < 24; k++) send(4, 8'sd3, 8'sd2);
    repeat (20) step();
    check_val("tim_count", ot_cyc.size(), 3);
    for (int k = 0; k < 3; k++)
      check_val($sformatf("tim_lat_%0d", k), ot_cyc[k] - tk_cyc[8*k+7], LAT);

    // Runtime ratio change: 8 -> 16 written mid-period, then 1 (treated as 2)
    decim = 12'd8;
    do_reset("rst_ratio");
    for (int k = 0; k < 28; k++) begin
      if (k == 4)  decim = 12'd16;
      if (k == 12) decim = 12'd1;
      send(8, 8'sd0, 8'sd0);
    end
    repeat (20) step();
    check_val("ratio_count", ot_cyc.size(), 4);
    check_val("ratio_p0", ot_cyc[0] - tk_cyc[7],  LAT);
    check_val("ratio_p1", ot_cyc[1] - tk_cyc[23], LAT);
    check_val("ratio_p2", ot_cyc[2] - tk_cyc[25], LAT);
    check_val("ratio_p3", ot_cyc[3] - tk_cyc[27], LAT);

    // Overrun: R=2 with a tick every cycle, then back to a sustainable rate
    decim = 12'd2;
    do_reset("rst_ovr");
    for (int k = 0; k < 40; k++) send(1, 8'sd1, -8'sd1);
    check_val("ovr_seen", (ovr_cnt > 0), 1);
    min_gap = 1000;
    for (int k = 1; k < ot_cyc.size(); k++)
      if (ot_cyc[k] - ot_cyc[k-1] < min_gap) min_gap = ot_cyc[k] - ot_cyc[k-1];
    check_val("ovr_min_gap_ok", (min_gap >= LAT), 1);
    for (int k = 0; k < 16; k++) send(8, 8'sd1, -8'sd1);
    repeat (20) step();
    check_val("ovr_settled_i", ot_i[ot_i.size()-1], 32);
    check_val("ovr_settled_q", ot_q[ot_q.size()-1], -32);
    check_val("ovr_settled_sat", ot_sat[ot_sat.size()-1], 0);

    // Reset during COMB_Q aborts the sample; the next output has normal latency
    decim = 12'd4;
    do_reset("rst_pre_cq");
    for (int k = 0; k < 4; k++) send(4, 8'sd1, -8'sd1);
    repeat (3) step();
    do_reset("rst_cq");
    repeat (20) step();
    check_val("cq_no_tick", ot_cyc.size(), 0);
    for (int k = 0; k < 32; k++) send(4, 8'sd1, -8'sd1);
    repeat (20) step();
    check_val("cq_count", ot_cyc.size(), 8);
    check_val("cq_first_lat", ot_cyc[0] - tk_cyc[3], LAT);
    check_val("cq_i", ot_i[7], 1024);
    check_val("cq_q", ot_q[7], -1024);

    // Saturation through integrator wrap at R=4095, then shift=56 brings it in range
    decim = 12'd4095;
    shift = 7'd0;
    do_reset("rst_sat");
    for (int k = 0; k < 7*4095; k++) send(1, 8'sd127, -8'sd128);
    repeat (20) step();
    check_val("sat_count", ot_cyc.size(), 7);
    for (int k = 5; k < 7; k++) begin
      check_val($sformatf("sat_i_%0d", k), ot_i[k], 32767);
      check_val($sformatf("sat_q_%0d", k), ot_q[k], -32768);
      check_val($sformatf("sat_flag_%0d", k), ot_sat[k], 1);
    end
    shift = 7'd56;
    for (int k = 0; k < 2*4095; k++) send(1, 8'sd127, -8'sd128);
    repeat (20) step();
    check_val("shift_count", ot_cyc.size(), 9);
    check_val("shift_i", ot_i[8], 2029);
    check_val("shift_q", ot_q[8], -2046);
    check_val("shift_sat", ot_sat[8], 0);

    check_val("out_tick_width", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
